// File: rtl/bk_adder_pipe.sv
// bk_adder_pipe: two-stage pipelined Brent-Kung adder/subtractor with a
// valid/ready handshake on both sides.
// Optional feature: define BK_ADDER_PIPE_FLAGS_EN to add the registered
// {overflow, negative, zero} flags output.
module bk_adder_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] c
`ifdef BK_ADDER_PIPE_FLAGS_EN
    ,
    output logic [2:0]       flags
`endif
);

    localparam int LVL = $clog2(WIDTH);

    // Effective operands; carry-in folds into the bit-0 generate so every
    // prefix generate is directly the carry out of that bit.
    logic [WIDTH-1:0] b_eff, g_leaf, p_leaf;
    logic             c0;

    assign b_eff  = sub ? ~b : b;
    assign c0     = sub | cin;
    assign p_leaf = a ^ b_eff;
    assign g_leaf = {a[WIDTH-1:1] & b_eff[WIDTH-1:1], (a[0] & b_eff[0]) | (p_leaf[0] & c0)};

    // Up-sweep: level lv combines nodes whose index+1 is a multiple of 2^(lv+1).
    for (genvar lv = 0; lv < LVL; lv++) begin : g_up
        logic [WIDTH-1:0] g_i, p_i, g_o, p_o;
        if (lv == 0) begin : g_src
            assign g_i = g_leaf;
            assign p_i = p_leaf;
        end else begin : g_src
            assign g_i = g_up[lv-1].g_o;
            assign p_i = g_up[lv-1].p_o;
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i + 1) % (2 ** (lv + 1))) == 0) begin : g_node
                assign g_o[i] = g_i[i] | (p_i[i] & g_i[i-2**lv]);
                assign p_o[i] = p_i[i] & p_i[i-2**lv];
            end else begin : g_pass
                assign g_o[i] = g_i[i];
                assign p_o[i] = p_i[i];
            end
        end
    end

    // Stage S1 registers: bit propagates, carry-in and the up-sweep group terms.
    logic             s1_vld_q, s2_vld_q;
    logic [WIDTH-1:0] p_q, gg_q, gp_q;
    logic             c0_q;
    logic             s1_load, s2_load;

    assign s2_load   = !s2_vld_q || out_ready;
    assign s1_load   = !s1_vld_q || s2_load;
    assign in_ready  = !s1_vld_q || !s2_vld_q || out_ready;
    assign out_valid = s2_vld_q;

    // Stage occupancy; reset empties both stages immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            if (s1_load) s1_vld_q <= in_valid;
            if (s2_load) s2_vld_q <= s1_vld_q;
        end
    end

    // S1 datapath capture; contents are only meaningful while s1_vld_q is set.
    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            p_q  <= p_leaf;
            gg_q <= g_up[LVL-1].g_o;
            gp_q <= g_up[LVL-1].p_o;
            c0_q <= c0;
        end
    end

    // Leaf and root group-propagate terms are not consumed by the down-sweep.
    logic unused_gp;
    assign unused_gp = ^gp_q;

    // Down-sweep: fills in the carries at the nodes the up-sweep skipped.
    for (genvar k = 0; k < LVL - 1; k++) begin : g_dn
        localparam int LV = LVL - 2 - k;
        logic [WIDTH-1:0] g_i, g_o;
        if (k == 0) begin : g_src
            assign g_i = gg_q;
        end else begin : g_src
            assign g_i = g_dn[k-1].g_o;
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i >= 3 * 2 ** LV - 1) && (((i + 1 - 3 * 2 ** LV) % (2 ** (LV + 1))) == 0)) begin : g_node
                assign g_o[i] = g_i[i] | (gp_q[i] & g_i[i-2**LV]);
            end else begin : g_pass
                assign g_o[i] = g_i[i];
            end
        end
    end

    logic [WIDTH-1:0] cy, c_d, sum_d;
    logic             cout_d;

    assign cy     = g_dn[LVL-2].g_o;
    assign c_d    = {cy[WIDTH-2:0], c0_q};
    assign sum_d  = p_q ^ c_d;
    assign cout_d = cy[WIDTH-1];

    // Stage S2 result registers; hold while the consumer stalls.
    logic [WIDTH-1:0] sum_q, c_q;
    logic             cout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            c_q    <= '0;
            cout_q <= 1'b0;
        end else if (s2_load && s1_vld_q) begin
            sum_q  <= sum_d;
            c_q    <= c_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign c    = c_q;
    assign cout = cout_q;

`ifdef BK_ADDER_PIPE_FLAGS_EN
    logic [2:0] flags_d, flags_q;

    assign flags_d = {c_d[WIDTH-1] ^ cout_d, sum_d[WIDTH-1], sum_d == '0};

    // Status flags registered alongside the sum they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 3'b000;
        end else if (s2_load && s1_vld_q) begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`endif

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Bench for bk_adder_pipe: three instances (WIDTH 8/32/64) driven from one
// shared stimulus stream, checked against an arithmetic scoreboard model.
module tb_bk_adder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;

    always #5 clk = ~clk;

    logic        rdy8, rdy32, rdy64, ov8, ov32, ov64, co8, co32, co64;
    logic [7:0]  s8, c8;
    logic [31:0] s32, c32;
    logic [63:0] s64, c64;
`ifdef BK_ADDER_PIPE_FLAGS_EN
    logic [2:0]  f8, f32, f64;
`endif

    bk_adder_pipe #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .a(a[7:0]), .b(b[7:0]), .cin(cin), .sub(sub),
        .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(co8), .c(c8)
`ifdef BK_ADDER_PIPE_FLAGS_EN
        , .flags(f8)
`endif
    );

    bk_adder_pipe #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
        .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32), .c(c32)
`ifdef BK_ADDER_PIPE_FLAGS_EN
        , .flags(f32)
`endif
    );

    bk_adder_pipe #(.WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov64), .out_ready(out_ready), .sum(s64), .cout(co64), .c(c64)
`ifdef BK_ADDER_PIPE_FLAGS_EN
        , .flags(f64)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference: plain W+1-bit addition; carries into each bit recovered as sum^a^b'.
    task automatic model(input int w, input logic [63:0] ai, input logic [63:0] bi,
                         input logic ci, input logic su,
                         output logic [63:0] s, output logic [63:0] cv,
                         output logic co, output logic [2:0] fl);
        logic [64:0] m, aa, bb, full;
        m    = (65'd1 << w) - 65'd1;
        aa   = {1'b0, ai} & m;
        bb   = {1'b0, (su ? ~bi : bi)} & m;
        full = aa + bb + {64'd0, (su | ci)};
        s    = full[63:0] & m[63:0];
        co   = full[w];
        cv   = s ^ aa[63:0] ^ bb[63:0];
        fl   = {cv[w-1] ^ co, s[w-1], (s == 64'd0)};
    endtask

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic        lit;
        logic [31:0] ls;
        logic [31:0] lc;
        logic        lco;
        logic [2:0]  lf;
        logic [31:0] t;
    } ent_t;

    ent_t        q[$];
    int          nidx = 0;
    int          acc_cnt = 0;
    logic        lit_en = 1'b0;
    logic [31:0] lit_s = '0, lit_c = '0;
    logic        lit_co = 1'b0;
    logic [2:0]  lit_f = '0;
    logic        stall_prev = 1'b0;
    logic [31:0] held_s, held_c;

    task automatic check_result(input ent_t e);
        logic [63:0] es, ec;
        logic        eco;
        logic [2:0]  ef;
        model(8, e.a, e.b, e.cin, e.sub, es, ec, eco, ef);
        cmp("sum8", {56'd0, s8}, es);
        cmp("c8", {56'd0, c8}, ec);
        cmp("cout8", {63'd0, co8}, {63'd0, eco});
`ifdef BK_ADDER_PIPE_FLAGS_EN
        cmp("flags8", {61'd0, f8}, {61'd0, ef});
`endif
        model(32, e.a, e.b, e.cin, e.sub, es, ec, eco, ef);
        cmp("sum32", {32'd0, s32}, es);
        cmp("c32", {32'd0, c32}, ec);
        cmp("cout32", {63'd0, co32}, {63'd0, eco});
`ifdef BK_ADDER_PIPE_FLAGS_EN
        cmp("flags32", {61'd0, f32}, {61'd0, ef});
`endif
        model(64, e.a, e.b, e.cin, e.sub, es, ec, eco, ef);
        cmp("sum64", s64, es);
        cmp("c64", c64, ec);
        cmp("cout64", {63'd0, co64}, {63'd0, eco});
`ifdef BK_ADDER_PIPE_FLAGS_EN
        cmp("flags64", {61'd0, f64}, {61'd0, ef});
`endif
        if (e.lit) begin
            cmp("lit_sum32", {32'd0, s32}, {32'd0, e.ls});
            cmp("lit_c32", {32'd0, c32}, {32'd0, e.lc});
            cmp("lit_cout32", {63'd0, co32}, {63'd0, e.lco});
`ifdef BK_ADDER_PIPE_FLAGS_EN
            cmp("lit_flags32", {61'd0, f32}, {61'd0, e.lf});
`endif
        end
    endtask

    // Compare process: handshake expectations and results every cycle.
    always @(negedge clk) begin
        logic exp_ov, exp_ir;
        ent_t e;
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
            cmp("rst_out_valid", {61'd0, ov8, ov32, ov64}, 64'd0);
            cmp("rst_in_ready", {61'd0, rdy8, rdy32, rdy64}, 64'd7);
            cmp("rst_sum", {s32, s8, 24'd0}, 64'd0);
            cmp("rst_sum64", s64, 64'd0);
            cmp("rst_c", {c32, c8, 21'd0, co8, co32, co64}, 64'd0);
        end else begin
            exp_ov = (q.size() > 0) && (nidx - int'(q[0].t) >= 2);
            exp_ir = (q.size() < 2) || out_ready;
            cmp("out_valid", {61'd0, ov8, ov32, ov64}, {61'd0, {3{exp_ov}}});
            cmp("in_ready", {61'd0, rdy8, rdy32, rdy64}, {61'd0, {3{exp_ir}}});
            if (stall_prev) cmp("hold_sum_c32", {s32, c32}, {held_s, held_c});
            if (ov32 && out_ready && q.size() > 0) begin
                e = q.pop_front();
                check_result(e);
            end
            stall_prev = ov32 && !out_ready;
            held_s = s32;
            held_c = c32;
            if (in_valid && rdy32) begin
                e = '{a: a, b: b, cin: cin, sub: sub, lit: lit_en, ls: lit_s, lc: lit_c,
                      lco: lit_co, lf: lit_f, t: nidx};
                q.push_back(e);
                acc_cnt++;
            end
        end
        nidx++;
    end

    task automatic send(input logic [63:0] aa, input logic [63:0] bb, input logic ci, input logic su);
        logic acc, ok;
        ok = 1'b0;
        a = aa; b = bb; cin = ci; sub = su; in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = rdy32;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        lit_en = 1'b0;
        if (!ok) cmp("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_lit(input logic [31:0] aa, input logic [31:0] bb, input logic su,
                            input logic [31:0] es, input logic [31:0] ec,
                            input logic eco, input logic [2:0] ef);
        lit_en = 1'b1; lit_s = es; lit_c = ec; lit_co = eco; lit_f = ef;
        send({32'd0, aa}, {32'd0, bb}, 1'b0, su);
    endtask

    task automatic pin_model(input string nm, input logic [31:0] aa, input logic [31:0] bb,
                             input logic su, input logic [31:0] es, input logic [31:0] ec,
                             input logic eco, input logic [2:0] ef);
        logic [63:0] s, cv;
        logic        co;
        logic [2:0]  fl;
        model(32, {32'd0, aa}, {32'd0, bb}, 1'b0, su, s, cv, co, fl);
        cmp({nm, "_sum"}, s, {32'd0, es});
        cmp({nm, "_c"}, cv, {32'd0, ec});
        cmp({nm, "_cout"}, {63'd0, co}, {63'd0, eco});
        cmp({nm, "_flags"}, {61'd0, fl}, {61'd0, ef});
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_8000_0080;
            3:       return 64'h7FFF_FFFF_7FFF_FF7F;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int target, budget;
        #1 rst = 1'b1;
        pin_model("model_ovf", 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 32'hFFFFFFFE, 1'b1, 3'b001);
        pin_model("model_sub", 32'h5, 32'h7, 1'b1, 32'hFFFFFFFE, 32'h3, 1'b0, 3'b010);
        pin_model("model_sov", 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 32'hFFFFFFFE, 1'b0, 3'b110);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        // First operand offered in the same step reset is released.
        send_lit(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 32'hFFFFFFFE, 1'b1, 3'b001);
        send_lit(32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 32'h00000003, 1'b0, 3'b010);
        send_lit(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 32'hFFFFFFFE, 1'b0, 3'b110);
        repeat (4) @(posedge clk);
        #1;
        // Back-pressure: three inputs while the consumer stalls for 4 cycles.
        out_ready = 1'b0;
        send(64'h1111_1111_1234_5678, 64'h2222_2222_0000_0001, 1'b1, 1'b0);
        send(64'h0F0F_0F0F_0000_00F0, 64'h0101_0101_0000_0010, 1'b0, 1'b1);
        fork
            send(64'hDEAD_BEEF_CAFE_F00D, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        // Reset with two results in flight.
        out_ready = 1'b0;
        send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 1'b0);
        send(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0009, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        cmp("async_rst_out_valid", {61'd0, ov8, ov32, ov64}, 64'd0);
        cmp("async_rst_in_ready", {61'd0, rdy8, rdy32, rdy64}, 64'd7);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        send(64'h0000_0001_0000_0100, 64'h0000_0002_0000_0200, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        // Random add/sub with random stalls on both sides.
        target = acc_cnt + 10000;
        budget = 0;
        while (acc_cnt < target && budget < 60000) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = rnd64();
            b   = rnd64();
            cin = $urandom_range(0, 1) == 1;
            sub = $urandom_range(0, 1) == 1;
            budget++;
        end
        if (acc_cnt < target) cmp("random_accept_budget", 64'(acc_cnt), 64'(target));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        cmp("drain_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
